// File: rtl/fetch_unit_if.sv
// ============================================================================
//  Module   : fetch_unit_if
//  Brief    : Fetch-stage bus bundle: instruction-memory request/response,
//             redirect input, decode-side stall and buffered instruction out.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if;
    // Instruction-memory request (valid/ready) and response (valid only)
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    // Control-flow redirect from the PC-select logic
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Decode side
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misalign_err;

    // Fetch-unit side
    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_addr,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        input  stall,
        output inst_valid,
        output inst,
        output inst_pc,
        output misalign_err
    );

    // Environment side (memory, PC-select, decoder)
    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_addr,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        output stall,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        input  misalign_err
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Instruction fetch stage. Holds the PC, keeps at most one
//             instruction-memory request in flight, buffers one instruction
//             for decode and applies redirects by killing the in-flight fetch.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  wire logic   clk,
    input  wire logic   rst,
    fetch_unit_if.master bus
);

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;          // next address to fetch
    logic [31:0] req_pc_q;      // address of the request currently in flight
    logic        kill_q;        // in-flight response must be discarded
    logic        inst_valid_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;

    logic        w_req_valid;
    logic        w_req_fire;
    logic [31:0] w_redirect_pc;

    // A request is offered only from REQ, never while redirecting, and only
    // when the buffer is empty or is being consumed this cycle.
    assign w_req_valid   = !rst && (state_q == ST_REQ) && !bus.redirect_valid &&
                           (!inst_valid_q || !bus.stall);
    assign w_req_fire    = w_req_valid && bus.imem_req_ready;
    assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_valid_q ? inst_q : NOP_INST;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.misalign_err   = !rst && bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

    // Fetch FSM, PC and output buffer; redirect overrides normal sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            kill_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= RESET_PC;
        end else begin
            // Decode consumes the buffer; a load below may replace it.
            if (inst_valid_q && !bus.stall) begin
                inst_valid_q <= 1'b0;
            end

            if (bus.redirect_valid) begin
                pc_q         <= w_redirect_pc;
                inst_valid_q <= 1'b0;
                if (state_q == ST_WAIT) begin
                    if (bus.imem_resp_valid) begin
                        // The in-flight response lands now; drop it directly.
                        state_q <= ST_REQ;
                        kill_q  <= 1'b0;
                    end else begin
                        kill_q  <= 1'b1;
                    end
                end
            end else begin
                case (state_q)
                    ST_REQ: begin
                        if (w_req_fire) begin
                            req_pc_q <= pc_q;
                            pc_q     <= pc_q + 32'd4;
                            state_q  <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.imem_resp_valid) begin
                            if (kill_q) begin
                                kill_q <= 1'b0;
                            end else begin
                                inst_q       <= bus.imem_resp_data;
                                inst_pc_q    <= req_pc_q;
                                inst_valid_q <= 1'b1;
                            end
                            state_q <= ST_REQ;
                        end
                    end
                    default: state_q <= ST_REQ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Self-checking bench for fetch_unit with a behavioural memory
//             and a transaction-level reference model of the fetch stream.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_2000;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    logic clk;
    logic rst;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (C_RESET_PC),
        .NOP_INST (C_NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus controls applied on the next step
    logic        c_rst, c_stall, c_ready, c_redir;
    logic [31:0] c_rpc;
    int          lat;

    // Values sampled during the last step
    logic        s_req, s_iv, s_mis;
    logic [31:0] s_addr, s_inst, s_ipc;

    logic [31:0] acc_log[$];
    logic [31:0] iv_log[$];

    // Reference model: fetch stream view
    logic [31:0] m_fetch, m_inflight, m_buf_pc;
    logic        m_out, m_want, m_buf_v;

    // Memory model: one outstanding request, fixed latency per request
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_due;
    int          cyc = 0;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic model_reset();
        m_fetch  = C_RESET_PC;
        m_out    = 1'b0;
        m_want   = 1'b0;
        m_buf_v  = 1'b0;
        m_buf_pc = C_RESET_PC;
        mem_pend = 1'b0;
    endtask

    // One clock cycle: drive, sample, compare against the model, advance it.
    task automatic step();
        logic exp_req, exp_mis, acc_dut, delivered;
        @(negedge clk);
        rst                = c_rst;
        bus.stall          = c_stall;
        bus.imem_req_ready = c_ready;
        bus.redirect_valid = c_redir;
        bus.redirect_pc    = c_rpc;
        if (mem_pend && cyc == mem_due) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = tag(mem_addr);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = $urandom;
        end
        #1;
        s_req  = bus.imem_req_valid;
        s_addr = bus.imem_addr;
        s_iv   = bus.inst_valid;
        s_inst = bus.inst;
        s_ipc  = bus.inst_pc;
        s_mis  = bus.misalign_err;

        exp_req = !c_rst && !m_out && !c_redir && (!m_buf_v || !c_stall);
        exp_mis = c_redir && (c_rpc[1:0] != 2'b00);
        n_checks++;
        if (s_req !== exp_req) begin
            n_errors++;
            $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, s_req, exp_req);
        end
        if (!c_rst) begin
            if (exp_req) begin
                n_checks++;
                if (s_addr !== m_fetch) begin
                    n_errors++;
                    $display("FAIL imem_addr cyc=%0d: got %h expected %h", cyc, s_addr, m_fetch);
                end
            end
            n_checks++;
            if (s_iv !== m_buf_v) begin
                n_errors++;
                $display("FAIL inst_valid cyc=%0d: got %b expected %b", cyc, s_iv, m_buf_v);
            end
            n_checks++;
            if (m_buf_v) begin
                if (s_ipc !== m_buf_pc || s_inst !== tag(m_buf_pc)) begin
                    n_errors++;
                    $display("FAIL inst cyc=%0d: got pc %h inst %h expected pc %h inst %h",
                             cyc, s_ipc, s_inst, m_buf_pc, tag(m_buf_pc));
                end
            end else if (s_inst !== C_NOP) begin
                n_errors++;
                $display("FAIL inst_nop cyc=%0d: got %h expected %h", cyc, s_inst, C_NOP);
            end
            n_checks++;
            if (s_mis !== exp_mis) begin
                n_errors++;
                $display("FAIL misalign_err cyc=%0d: got %b expected %b", cyc, s_mis, exp_mis);
            end
        end

        acc_dut = s_req && c_ready;
        if (acc_dut) acc_log.push_back(s_addr);
        if (s_iv && !c_rst) iv_log.push_back(s_ipc);

        if (c_rst) begin
            model_reset();
        end else begin
            delivered = bus.imem_resp_valid && m_out && m_want && !c_redir;
            if (bus.imem_resp_valid) begin
                m_out    = 1'b0;
                mem_pend = 1'b0;
            end
            if (c_redir)        m_buf_v = 1'b0;
            else if (delivered) begin
                m_buf_v  = 1'b1;
                m_buf_pc = m_inflight;
            end else if (!c_stall) m_buf_v = 1'b0;
            if (c_redir) begin
                m_fetch = {c_rpc[31:2], 2'b00};
                m_want  = 1'b0;
            end
            if (exp_req && c_ready) begin
                m_inflight = m_fetch;
                m_fetch    = m_fetch + 32'd4;
                m_out      = 1'b1;
                m_want     = 1'b1;
            end
            if (acc_dut) begin
                mem_pend = 1'b1;
                mem_addr = s_addr;
                mem_due  = cyc + lat;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        c_rst = 1'b1; c_stall = 1'b0; c_ready = 1'b1; c_redir = 1'b0; c_rpc = '0; lat = 1;
        step();
        step();
        c_rst = 1'b0;
        acc_log.delete();
        iv_log.delete();
    endtask

    task automatic test_reset();
        do_reset();
        step();
        n_checks++;
        if (s_iv !== 1'b0 || s_inst !== C_NOP || s_ipc !== C_RESET_PC || s_mis !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got iv=%b inst=%h pc=%h mis=%b expected 0/%h/%h/0",
                     s_iv, s_inst, s_ipc, s_mis, C_NOP, C_RESET_PC);
        end
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== C_RESET_PC) begin
            n_errors++;
            $display("FAIL reset_first_req: got valid=%b addr=%h expected 1/%h", s_req, s_addr, C_RESET_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_a;
        do_reset();
        for (int i = 0; i < 9; i++) step();
        for (int i = 0; i < 3; i++) begin
            exp_a = C_RESET_PC + 32'(4 * i);
            n_checks++;
            if (acc_log.size() <= i || acc_log[i] !== exp_a) begin
                n_errors++;
                $display("FAIL seq_req_addr[%0d]: got %h expected %h", i,
                         (acc_log.size() > i) ? acc_log[i] : 32'hx, exp_a);
            end
            n_checks++;
            if (iv_log.size() <= i || iv_log[i] !== exp_a) begin
                n_errors++;
                $display("FAIL seq_inst_pc[%0d]: got %h expected %h", i,
                         (iv_log.size() > i) ? iv_log[i] : 32'hx, exp_a);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();                 // accept 0x2000
        c_stall = 1'b1;
        step();                 // response lands
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (s_iv !== 1'b1 || s_ipc !== C_RESET_PC || s_inst !== tag(C_RESET_PC) || s_req !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got iv=%b pc=%h inst=%h req=%b expected 1/%h/%h/0",
                         i, s_iv, s_ipc, s_inst, s_req, C_RESET_PC, tag(C_RESET_PC));
            end
        end
        c_stall = 1'b0;
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_2004) begin
            n_errors++;
            $display("FAIL stall_release_req: got valid=%b addr=%h expected 1/00002004", s_req, s_addr);
        end
    endtask

    task automatic test_ready_low();
        do_reset();
        step();
        step();
        c_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h0000_2004) begin
                n_errors++;
                $display("FAIL ready_low_hold[%0d]: got valid=%b addr=%h expected 1/00002004", i, s_req, s_addr);
            end
        end
        c_ready = 1'b1;
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_2004) begin
            n_errors++;
            $display("FAIL ready_accept: got valid=%b addr=%h expected 1/00002004", s_req, s_addr);
        end
        step();
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_2008) begin
            n_errors++;
            $display("FAIL ready_next_pc: got valid=%b addr=%h expected 1/00002008", s_req, s_addr);
        end
    endtask

    task automatic test_redirect_kill();
        do_reset();
        lat = 2;
        step();                 // accept 0x2000, response two cycles later
        c_redir = 1'b1; c_rpc = 32'h0000_3000;
        step();
        n_checks++;
        if (s_req !== 1'b0) begin
            n_errors++;
            $display("FAIL kill_redirect_req: got %b expected 0", s_req);
        end
        c_redir = 1'b0; lat = 1;
        step();                 // stale response arrives
        n_checks++;
        if (s_iv !== 1'b0 || s_req !== 1'b0) begin
            n_errors++;
            $display("FAIL kill_stale: got iv=%b req=%b expected 0/0", s_iv, s_req);
        end
        step();
        n_checks++;
        if (s_iv !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h0000_3000) begin
            n_errors++;
            $display("FAIL kill_next_req: got iv=%b req=%b addr=%h expected 0/1/00003000", s_iv, s_req, s_addr);
        end
        step();
        step();
        n_checks++;
        if (s_iv !== 1'b1 || s_ipc !== 32'h0000_3000) begin
            n_errors++;
            $display("FAIL kill_deliver: got iv=%b pc=%h expected 1/00003000", s_iv, s_ipc);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        c_ready = 1'b0;
        step();
        c_redir = 1'b1; c_rpc = 32'h0000_3002;
        step();
        n_checks++;
        if (s_mis !== 1'b1 || s_req !== 1'b0) begin
            n_errors++;
            $display("FAIL misalign_pulse: got mis=%b req=%b expected 1/0", s_mis, s_req);
        end
        c_redir = 1'b0; c_ready = 1'b1;
        step();
        n_checks++;
        if (s_mis !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h0000_3000) begin
            n_errors++;
            $display("FAIL misalign_after: got mis=%b req=%b addr=%h expected 0/1/00003000", s_mis, s_req, s_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        c_ready = 1'b0;
        c_redir = 1'b1; c_rpc = 32'hFFFF_FFFC;
        step();
        c_redir = 1'b0; c_ready = 1'b1;
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
            n_errors++;
            $display("FAIL wrap_top: got valid=%b addr=%h expected 1/fffffffc", s_req, s_addr);
        end
        step();
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_0000) begin
            n_errors++;
            $display("FAIL wrap_zero: got valid=%b addr=%h expected 1/00000000", s_req, s_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        lat = 3;
        step();                 // accept 0x2000
        step();                 // WAIT
        c_rst = 1'b1;
        step();
        step();
        n_checks++;
        if (s_iv !== 1'b0 || s_req !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_wait: got iv=%b req=%b expected 0/0", s_iv, s_req);
        end
        c_rst = 1'b0;
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== C_RESET_PC) begin
            n_errors++;
            $display("FAIL rst_first_req: got valid=%b addr=%h expected 1/%h", s_req, s_addr, C_RESET_PC);
        end
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            c_stall = ($urandom_range(0, 99) < 30);
            c_ready = ($urandom_range(0, 99) < 70);
            c_redir = ($urandom_range(0, 99) < 8);
            c_rpc   = ($urandom_range(0, 3) == 0) ? $urandom : (32'h0000_4000 + 32'($urandom_range(0, 255)));
            lat     = $urandom_range(1, 3);
            c_rst   = ($urandom_range(0, 199) == 0);
            if (c_rst) c_redir = 1'b0;
            step();
        end
        c_rst = 1'b0; c_redir = 1'b0; c_stall = 1'b0; c_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        bus.stall           = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        c_rst = 1'b1; c_stall = 1'b0; c_ready = 1'b1; c_redir = 1'b0; c_rpc = '0; lat = 1;
        model_reset();

        test_reset();
        test_sequential();
        test_stall();
        test_ready_low();
        test_redirect_kill();
        test_misalign();
        test_wrap();
        test_reset_in_wait();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
